// File: rtl/pipe_mdu_seq_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: request, shared-ALU
// steering, status and the architectural HI/LO results.
interface pipe_mdu_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        cancel;
  logic [31:0] alu_r;
  logic        alu_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_aluc;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, opa, opb, cancel, alu_r,
    input  alu_sel, alu_a, alu_b, alu_aluc, busy, done, hi, lo
  );

  modport slave (
    input  start, op, opa, opb, cancel, alu_r,
    output alu_sel, alu_a, alu_b, alu_aluc, busy, done, hi, lo
  );
endinterface

// File: rtl/pipe_mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the pipeline's shared
// 32-bit ALU for 32 shift-add / restoring-divide steps, then sign-fixes into HI/LO.
module pipe_mdu_seq (
  input  logic          clk,
  input  logic          clrn,
  pipe_mdu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_reg, state_next;
  logic        op_div_reg, op_div_next;
  logic        neg_a_reg, neg_a_next;
  logic        neg_b_reg, neg_b_next;
  logic [31:0] acc_reg, acc_next;
  logic [31:0] q_reg, q_next;
  logic [31:0] m_reg, m_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [4:0]  cnt_reg, cnt_next;

  logic        alu_sel;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        signed_op;
  logic        carry, borrow, qbit;
  logic [63:0] prod;

  assign alu_r = bus.alu_r;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_reg  <= S_IDLE;
      op_div_reg <= 1'b0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      acc_reg    <= 32'd0;
      q_reg      <= 32'd0;
      m_reg      <= 32'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      cnt_reg    <= 5'd0;
    end else begin
      state_reg  <= state_next;
      op_div_reg <= op_div_next;
      neg_a_reg  <= neg_a_next;
      neg_b_reg  <= neg_b_next;
      acc_reg    <= acc_next;
      q_reg      <= q_next;
      m_reg      <= m_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_div_next = op_div_reg;
    neg_a_next  = neg_a_reg;
    neg_b_next  = neg_b_reg;
    acc_next    = acc_reg;
    q_next      = q_reg;
    m_next      = m_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    cnt_next    = cnt_reg;
    alu_sel     = 1'b0;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_aluc    = 4'b0000;
    signed_op   = 1'b0;
    carry       = 1'b0;
    borrow      = 1'b0;
    qbit        = 1'b0;
    prod        = 64'd0;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          // Magnitudes go straight into q/m; only the sign flags are kept aside.
          signed_op   = bus.op[0];
          op_div_next = bus.op[1];
          neg_a_next  = signed_op & bus.opa[31];
          neg_b_next  = signed_op & bus.opb[31];
          q_next      = neg_a_next ? (~bus.opa + 32'd1) : bus.opa;
          m_next      = neg_b_next ? (~bus.opb + 32'd1) : bus.opb;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_next   = 32'd0;
        cnt_next   = 5'd31;
        state_next = S_RUN;
      end
      S_RUN: begin
        alu_sel = 1'b1;
        if (op_div_reg) begin
          alu_a    = {acc_reg[30:0], q_reg[31]};
          alu_b    = m_reg;
          alu_aluc = 4'b0100;
          borrow   = (~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_r[31]);
          // The bit shifted out of acc makes the partial remainder >= 2^32 > m.
          qbit     = acc_reg[31] | ~borrow;
          acc_next = qbit ? alu_r : alu_a;
          q_next   = {q_reg[30:0], qbit};
        end else begin
          alu_a    = acc_reg;
          alu_b    = q_reg[0] ? m_reg : 32'd0;
          alu_aluc = 4'b0000;
          carry    = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_r[31]);
          acc_next = {carry, alu_r[31:1]};
          q_next   = {alu_r[0], q_reg[31:1]};
        end
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd0) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        if (op_div_reg) begin
          lo_next = (neg_a_reg ^ neg_b_reg) ? (~q_reg + 32'd1) : q_reg;
          hi_next = neg_a_reg ? (~acc_reg + 32'd1) : acc_reg;
        end else begin
          prod = {acc_reg, q_reg};
          if (neg_a_reg ^ neg_b_reg) begin
            prod = ~prod + 64'd1;
          end
          hi_next = prod[63:32];
          lo_next = prod[31:0];
        end
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // An abort before commit leaves HI/LO untouched; DONE/IDLE are unaffected.
    if (bus.cancel && (state_reg == S_LOAD || state_reg == S_RUN || state_reg == S_FIX)) begin
      state_next = S_IDLE;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
    end
  end

  assign bus.alu_sel  = alu_sel;
  assign bus.alu_a    = alu_a;
  assign bus.alu_b    = alu_b;
  assign bus.alu_aluc = alu_aluc;
  assign bus.busy     = (state_reg == S_LOAD) || (state_reg == S_RUN) || (state_reg == S_FIX);
  assign bus.done     = (state_reg == S_DONE);
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_pipe_mdu_seq.sv
// Scoreboard bench for pipe_mdu_seq: driver pushes expected HI/LO from an
// arithmetic reference, a negedge monitor pops and compares on each done.
module tb_pipe_mdu_seq;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  pipe_mdu_seq_if bus ();

  pipe_mdu_seq dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  // Shared ALU model: plain add/sub.
  assign bus.alu_r = (bus.alu_aluc == 4'b0100) ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  typedef struct {
    logic [1:0]  op;
    logic [63:0] exp;
    int          t0;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sel_cnt = 0;
  int   txn_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, qt, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: r = {32'd0, a} * {32'd0, b};
      2'd1: r = sa * sb;
      2'd2: r = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) begin
          r = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
        end else begin
          qt = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], qt[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  // Monitor: ALU steering checks every cycle, result checks on done.
  always @(negedge clk) begin
    txn_t t;
    if (clrn) begin
      if (bus.alu_sel) begin
        sel_cnt++;
        check("sel_pending", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          check("aluc", 64'(bus.alu_aluc), exp_q[0].op[1] ? 64'd4 : 64'd0);
        end
      end else begin
        check("idle_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        check("idle_aluc", 64'(bus.alu_aluc), 64'd0);
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(bus.done), 64'd0);
        end else begin
          t = exp_q.pop_front();
          txn_no++;
          $display("txn %0d op=%0d hi=%h lo=%h exp=%h", txn_no, t.op, bus.hi, bus.lo, t.exp);
          check("hilo", {bus.hi, bus.lo}, t.exp);
          check("latency", 64'(cyc - t.t0), 64'd34);
          check("sel_cycles", 64'(sel_cnt), 64'd32);
        end
        sel_cnt = 0;
      end
    end
  end

  // mode: 0 normal, 1 cancel on 10th RUN cycle, 2 stray start while busy, 3 reset mid-RUN
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int mode);
    txn_t t;
    int   n;
    int   k;
    n = 0;
    while ((bus.busy || bus.done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("idle_before_start", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.opa   = $urandom;
    bus.opb   = $urandom;
    t.op  = op;
    t.exp = ref_model(op, a, b);
    t.t0  = cyc;
    exp_q.push_back(t);
    @(negedge clk);
    check("accept_busy", 64'(bus.busy), 64'd1);

    if (mode == 1 || mode == 3) begin
      k = 0;
      n = 0;
      while (k < ((mode == 1) ? 10 : 5) && n < 100) begin
        if (bus.alu_sel) k++;
        if (k < ((mode == 1) ? 10 : 5)) begin
          @(negedge clk);
          n++;
        end
      end
      check("reach_run", 64'(bus.alu_sel), 64'd1);
      if (mode == 1) bus.cancel = 1'b1;
      else clrn = 1'b0;
      @(posedge clk);
      #1;
      bus.cancel = 1'b0;
      void'(exp_q.pop_back());
      sel_cnt = 0;
      @(negedge clk);
      if (mode == 1) begin
        $display("txn cancelled op=%0d busy=%0d hi=%h lo=%h", op, bus.busy, bus.hi, bus.lo);
        check("cancel_busy", 64'(bus.busy), 64'd0);
        check("cancel_done", 64'(bus.done), 64'd0);
        check("cancel_hilo", {bus.hi, bus.lo}, {32'd1, 32'd2});
      end else begin
        $display("txn reset op=%0d busy=%0d hi=%h lo=%h", op, bus.busy, bus.hi, bus.lo);
        check("rst_ctrl", {57'd0, bus.busy, bus.done, bus.alu_sel, bus.alu_aluc}, 64'd0);
        check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        clrn = 1'b1;
      end
    end else begin
      if (mode == 2) begin
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = ~op;
        bus.opa   = ~a;
        bus.opb   = b + 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
      end
      n = 0;
      while (!bus.done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("done_seen", 64'(bus.done), 64'd1);
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    bus.start  = 1'b0;
    bus.op     = 2'd0;
    bus.opa    = 32'd0;
    bus.opb    = 32'd0;
    bus.cancel = 1'b0;
    clrn       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {57'd0, bus.busy, bus.done, bus.alu_sel, bus.alu_aluc}, 64'd0);
    check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    clrn = 1'b1;

    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    issue(2'd1, 32'hFFFFFFFD, 32'd7, 0);
    issue(2'd3, 32'hFFFFFFF9, 32'd2, 0);
    issue(2'd2, 32'd5, 32'd0, 0);
    issue(2'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    issue(2'd3, 32'hFFFFFFF0, 32'd0, 0);
    issue(2'd1, 32'h80000000, 32'h80000000, 0);
    issue(2'd2, 32'd5, 32'd2, 0);
    issue(2'd1, $urandom, $urandom, 1);
    issue(2'd2, 32'd100, 32'd7, 0);
    issue(2'd3, 32'h8765_4321, 32'h0000_1234, 2);
    issue(2'd0, $urandom, $urandom, 3);

    for (int i = 0; i < 32; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      issue(rop, ra, rb, 0);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
